// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

  // Default operand width for the serial adder.
  localparam int DEFAULT_WIDTH = 8;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sadd_state_t;

endpackage : serial_add_pkg

// File: rtl/serial_adder_ctrl_cell.sv
// Combinational one-bit full adder built from two half-adder stages.

module one_bit_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);

  assign s  = a ^ b;
  assign co = a & b;

endmodule : one_bit_adder

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s0_s;
  logic c0_s;
  logic c1_s;

  // First stage adds the operand bits.
  one_bit_adder u_ha0 (
    .a  (a),
    .b  (b),
    .s  (s0_s),
    .co (c0_s)
  );

  // Second stage folds in the incoming carry.
  one_bit_adder u_ha1 (
    .a  (s0_s),
    .b  (ci),
    .s  (s),
    .co (c1_s)
  );

  // At most one stage can generate a carry, so OR is exact.
  assign co = c0_s | c1_s;

endmodule : full_adder_cell

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: steps one shared full-adder cell LSB-first
// across a WIDTH-bit add, with valid/ready handshakes on both sides.
module serial_adder_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sadd_state_t      state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             cell_s_s;
  logic             cell_co_s;

  // The single shared adder cell always looks at the current LSBs and carry.
  full_adder_cell u_cell (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (cell_s_s),
    .co (cell_co_s)
  );

  // Next-state and datapath update; operands are captured only on accept,
  // and the visible sum/cout are written only on the final step.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = {CNT_W{1'b0}};
          acc_d   = {WIDTH{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        acc_d   = {cell_s_s, acc_q[WIDTH-1:1]};
        carry_d = cell_co_s;
        if (cnt_q == LAST_CNT) begin
          // Counter parks at its last value rather than wrapping.
          sum_d   = {cell_s_s, acc_q[WIDTH-1:1]};
          cout_d  = cell_co_s;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and handshake flops; handshakes follow the next state so
  // they never depend combinationally on in_valid or out_ready.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      sum_q       <= {WIDTH{1'b0}};
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule : serial_adder_ctrl
